// File: rtl/fifo_sync_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_fwft
//  Description : Single-clock first-word-fall-through FIFO. Inferred RAM feeds
//                a RAM read register and an output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_fwft #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 1024,
  parameter int AE_THRESH = 8,
  parameter int AF_THRESH = 1016
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       DI,
  input  logic                   WREN,
  output logic [WIDTH-1:0]       DO,
  input  logic                   RDEN,
  output logic                   EMPTY,
  output logic                   ALMOSTEMPTY,
  output logic                   FULL,
  output logic                   ALMOSTFULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mid_vld_q, mid_vld_d;
  logic [WIDTH-1:0] mid_data_q;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_ram_cnt;
  logic             w_mid_adv;
  logic             w_mid_load;

  always_comb begin
    w_wr_acc   = WREN && !full_q;
    w_rd_acc   = RDEN && out_vld_q;
    // Words still sitting in the RAM, i.e. not yet pulled into a prefetch stage.
    w_ram_cnt  = count_q - CW'(mid_vld_q) - CW'(out_vld_q);
    w_mid_adv  = mid_vld_q && (!out_vld_q || w_rd_acc);
    w_mid_load = (w_ram_cnt != '0) && (!mid_vld_q || w_mid_adv);

    count_d = count_q;
    if (w_wr_acc && !w_rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d   = w_wr_acc   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = w_mid_load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    mid_vld_d  = w_mid_load || (mid_vld_q && !w_mid_adv);
    out_vld_d  = w_mid_adv  || (out_vld_q && !w_rd_acc);
    out_data_d = w_mid_adv  ? mid_data_q : out_data_q;

    full_d   = (count_d == C_DEPTH);
    afull_d  = (count_d >= C_AF);
    aempty_d = (count_d <= C_AE);
    ovf_d    = ovf_q || (WREN && full_q);
    unf_d    = unf_q || (RDEN && !out_vld_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mid_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mid_vld_q  <= mid_vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage and its read register carry no reset so they map onto block RAM.
  // A read never targets the slot being written: that would require a full RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_acc && !RST) begin
      mem[wr_ptr_q] <= DI;
    end
    if (w_mid_load) begin
      mid_data_q <= mem[rd_ptr_q];
    end
  end

  assign DO          = out_data_q;
  assign EMPTY       = !out_vld_q;
  assign ALMOSTEMPTY = aempty_q;
  assign FULL        = full_q;
  assign ALMOSTFULL  = afull_q;
  assign COUNT       = count_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_sync_fwft
//  Description : Directed and random stimulus for fifo_sync_fwft, with a
//                negedge scoreboard that checks pop data and occupancy flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_fwft;

  localparam int W  = 36;
  localparam int D  = 16;
  localparam int AE = 2;
  localparam int AF = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  di;
  logic          wren;
  logic [W-1:0]  dout;
  logic          rden;
  logic          empty, aempty, full, afull, ovf, unf;
  logic [4:0]    count;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  logic [W-1:0] exp_q[$];
  int           m_count = 0;
  bit           m_ovf   = 1'b0;
  bit           m_unf   = 1'b0;

  fifo_sync_fwft #(.WIDTH(W), .DEPTH(D), .AE_THRESH(AE), .AF_THRESH(AF)) dut (
    .CLK(clk), .RST(rst), .DI(di), .WREN(wren), .DO(dout), .RDEN(rden),
    .EMPTY(empty), .ALMOSTEMPTY(aempty), .FULL(full), .ALMOSTFULL(afull),
    .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wren = 1'b0; rden = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: check state left by the last edge, then predict the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 64'(count), 64'(m_count));
      check("full", 64'(full), 64'(m_count == D));
      check("almostfull", 64'(afull), 64'(m_count >= AF));
      check("almostempty", 64'(aempty), 64'(m_count <= AE));
      check("overflow", 64'(ovf), 64'(m_ovf));
      check("underflow", 64'(unf), 64'(m_unf));
      if (m_count == 0) check("empty_when_count0", 64'(empty), 64'd1);
      if (rst) begin
        exp_q.delete();
        m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        bit wa, ra;
        wa = wren && (m_count != D);
        ra = rden && !empty;
        if (wren && m_count == D) m_ovf = 1'b1;
        if (rden && empty) m_unf = 1'b1;
        if (ra) begin
          if (exp_q.size() == 0) check("pop_with_empty_scoreboard", 64'(dout), 64'h0);
          else check("pop_data", 64'(dout), 64'(exp_q.pop_front()));
        end
        if (wa) exp_q.push_back(di);
        m_count = m_count + int'(wa) - int'(ra);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    int d;
    di = '0;
    rst = 1'b1; wren = 1'b0; rden = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: reset values and single-word fall-through latency
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_almostempty", 64'(aempty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_almostfull", 64'(afull), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_do", 64'(dout), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    check("rst_underflow", 64'(unf), 64'd0);
    v = 36'h9_DEAD_BEEF;
    wren = 1'b1; di = v;
    tick();
    wren = 1'b0;
    check("t1_count_after_write", 64'(count), 64'd1);
    check("t1_empty_edge1", 64'(empty), 64'd1);
    tick();
    check("t1_empty_edge2", 64'(empty), 64'd1);
    tick();
    check("t1_empty_edge3", 64'(empty), 64'd0);
    check("t1_do", 64'(dout), 64'h9_DEAD_BEEF);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    check("t1_empty_after_pop", 64'(empty), 64'd1);
    check("t1_count_after_pop", 64'(count), 64'd0);

    // 2: fill with thresholds
    for (int k = 0; k < 16; k++) begin
      wren = 1'b1; di = W'(k);
      tick();
      check("t2_almostempty", 64'(aempty), 64'(k + 1 <= 2));
      check("t2_almostfull", 64'(afull), 64'(k + 1 >= 14));
      check("t2_full", 64'(full), 64'(k + 1 == 16));
    end
    di = W'(99);
    tick();
    wren = 1'b0;
    check("t2_overflow", 64'(ovf), 64'd1);
    check("t2_count_held", 64'(count), 64'd16);

    // 3: drain at one word per cycle, then underflow
    rden = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t3_stream_do", 64'(dout), 64'(k));
      check("t3_stream_not_empty", 64'(empty), 64'd0);
      tick();
    end
    check("t3_empty", 64'(empty), 64'd1);
    check("t3_count", 64'(count), 64'd0);
    check("t3_underflow_before", 64'(unf), 64'd0);
    tick();
    rden = 1'b0;
    check("t3_underflow", 64'(unf), 64'd1);

    // 4: simultaneous read/write across pointer wrap, then at FULL
    do_reset();
    d = 1000;
    for (int k = 0; k < 5; k++) begin
      wren = 1'b1; di = W'(d); d++;
      tick();
    end
    wren = 1'b0;
    tick(); tick();
    wren = 1'b1; rden = 1'b1;
    for (int k = 0; k < 100; k++) begin
      di = W'(d); d++;
      tick();
    end
    wren = 1'b0; rden = 1'b0;
    check("t4_count_steady", 64'(count), 64'd5);
    for (int k = 0; k < 11; k++) begin
      wren = 1'b1; di = W'(d); d++;
      tick();
    end
    check("t4_full", 64'(full), 64'd1);
    wren = 1'b1; rden = 1'b1; di = W'(36'hF_0000_0000);
    tick();
    wren = 1'b0; rden = 1'b0;
    check("t4_count_full_rw", 64'(count), 64'd15);
    check("t4_overflow", 64'(ovf), 64'd1);
    check("t4_full_clear", 64'(full), 64'd0);

    // 5: reset while words are in flight
    do_reset();
    for (int k = 0; k < 9; k++) begin
      wren = 1'b1; di = W'(36'h5_0000_0000 + k);
      tick();
    end
    check("t5_count9", 64'(count), 64'd9);
    rst = 1'b1; wren = 1'b1; rden = 1'b1; di = W'(36'h7_7777_7777);
    tick();
    rst = 1'b0; wren = 1'b0; rden = 1'b0;
    check("t5_empty_after_rst", 64'(empty), 64'd1);
    check("t5_count_after_rst", 64'(count), 64'd0);
    wren = 1'b1; di = W'(36'hA_BCDE_0123);
    tick();
    wren = 1'b0;
    check("t5_empty_edge1", 64'(empty), 64'd1);
    tick();
    check("t5_empty_edge2", 64'(empty), 64'd1);
    tick();
    check("t5_empty_edge3", 64'(empty), 64'd0);
    check("t5_do", 64'(dout), 64'hA_BCDE_0123);
    rden = 1'b1;
    tick();
    rden = 1'b0;

    // 6: random traffic, then drain
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wren = 1'($urandom_range(0, 1));
      rden = 1'($urandom_range(0, 1));
      di   = {4'($urandom), 32'($urandom)};
      tick();
    end
    wren = 1'b0; rden = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    rden = 1'b0;
    tick();
    check("t6_scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("t6_empty_final", 64'(empty), 64'd1);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
